// File: rtl/frame_wr_addr_gen_if.sv
// AXI4 write-address channel bundle between frame_wr_addr_gen and the memory interconnect.
interface frame_wr_addr_gen_if #(
  parameter int C_ADDR_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;

  modport master (
    output awaddr,
    output awlen,
    output awvalid,
    input  awready
  );

  modport slave (
    input  awaddr,
    input  awlen,
    input  awvalid,
    output awready
  );
endinterface

// File: rtl/frame_wr_addr_gen.sv
// Write-side frame front end: turns s_sof into w_sof and walks one frame as AXI4 AW bursts.
// Optional macro FRAME_WR_4K_SPLIT_EN keeps every burst inside one 4 KiB page.
module frame_wr_addr_gen #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_BYTES = 8,
  parameter int C_BURST_MAX  = 16,
  parameter int C_LINE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_sof,
  output logic                    w_sof,
  input  logic [C_ADDR_WIDTH-1:0] w_addr,
  input  logic [C_LINE_WIDTH-1:0] line_beats,
  input  logic [C_LINE_WIDTH-1:0] lines,
  input  logic [C_ADDR_WIDTH-1:0] stride,
  frame_wr_addr_gen_if.master     m_axi,
  output logic                    frame_busy,
  output logic                    err_overrun
);

  localparam int ByteShift = $clog2(C_DATA_BYTES);
  // Burst-length arithmetic must hold a full row remainder and a full 4 KiB page in beats.
  localparam int CW = (C_LINE_WIDTH + 1 > 14) ? C_LINE_WIDTH + 1 : 14;
  localparam int OW = C_LINE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    ISSUE,
    WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] rowBase_q, rowBase_d;
  logic [OW-1:0]           rowIdx_q, rowIdx_d;
  logic [OW-1:0]           beatOff_q, beatOff_d;
  logic [C_LINE_WIDTH-1:0] lineBeats_q, lineBeats_d;
  logic [C_LINE_WIDTH-1:0] lines_q, lines_d;
  logic [C_ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d;
  logic [8:0]              burstLen_q, burstLen_d;
  logic                    errOverrun_q, errOverrun_d;

  logic [C_ADDR_WIDTH-1:0] issueAddr;
  logic [CW-1:0]           remainBeats;
  logic [CW-1:0]           burstLen;
  logic [OW-1:0]           nextOff;
  logic [OW-1:0]           nextRow;
`ifdef FRAME_WR_4K_SPLIT_EN
  logic [CW-1:0]           pageBeats;
`endif

  // Length of the burst about to be issued from the current row position.
  always_comb begin
    issueAddr   = rowBase_q + (C_ADDR_WIDTH'(beatOff_q) << ByteShift);
    remainBeats = CW'(lineBeats_q) - CW'(beatOff_q);
    burstLen    = (remainBeats > CW'(C_BURST_MAX)) ? CW'(C_BURST_MAX) : remainBeats;
`ifdef FRAME_WR_4K_SPLIT_EN
    pageBeats = (CW'(13'd4096) - CW'(issueAddr[11:0])) >> ByteShift;
    if (pageBeats == '0) begin
      pageBeats = CW'(1);
    end
    if (burstLen > pageBeats) begin
      burstLen = pageBeats;
    end
`endif
    nextOff = beatOff_q + OW'(burstLen_q);
    nextRow = rowIdx_q + OW'(1);
  end

  always_comb begin
    state_d      = state_q;
    rowBase_d    = rowBase_q;
    rowIdx_d     = rowIdx_q;
    beatOff_d    = beatOff_q;
    lineBeats_d  = lineBeats_q;
    lines_d      = lines_q;
    stride_d     = stride_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    awvalid_d    = awvalid_q;
    burstLen_d   = burstLen_q;
    errOverrun_d = s_sof && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (s_sof) begin
          state_d = LATCH;
        end
      end

      // The arbiter has switched buffers on the w_sof edge, so w_addr is the new frame base.
      LATCH: begin
        rowBase_d   = w_addr;
        lineBeats_d = line_beats;
        lines_d     = lines;
        stride_d    = stride;
        rowIdx_d    = '0;
        beatOff_d   = '0;
        if ((line_beats == '0) || (lines == '0)) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        awaddr_d   = issueAddr;
        awlen_d    = 8'(burstLen - CW'(1));
        burstLen_d = 9'(burstLen);
        awvalid_d  = 1'b1;
        state_d    = WAIT;
      end

      WAIT: begin
        if (m_axi.awready) begin
          awvalid_d = 1'b0;
          if (nextOff == OW'(lineBeats_q)) begin
            beatOff_d = '0;
            rowIdx_d  = nextRow;
            rowBase_d = rowBase_q + stride_q;
            state_d   = (nextRow == OW'(lines_q)) ? IDLE : ISSUE;
          end else begin
            beatOff_d = nextOff;
            state_d   = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rowBase_q    <= '0;
      rowIdx_q     <= '0;
      beatOff_q    <= '0;
      lineBeats_q  <= '0;
      lines_q      <= '0;
      stride_q     <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awvalid_q    <= 1'b0;
      burstLen_q   <= '0;
      errOverrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rowBase_q    <= rowBase_d;
      rowIdx_q     <= rowIdx_d;
      beatOff_q    <= beatOff_d;
      lineBeats_q  <= lineBeats_d;
      lines_q      <= lines_d;
      stride_q     <= stride_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      awvalid_q    <= awvalid_d;
      burstLen_q   <= burstLen_d;
      errOverrun_q <= errOverrun_d;
    end
  end

  assign w_sof         = s_sof && (state_q == IDLE);
  assign frame_busy    = (state_q != IDLE);
  assign err_overrun   = errOverrun_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awvalid = awvalid_q;

endmodule

// File: tb/tb_frame_wr_addr_gen.sv
// Scoreboard bench for frame_wr_addr_gen: expected bursts are queued at stimulus time and popped on each AW accept.
module tb_frame_wr_addr_gen;

  localparam int AW        = 32;
  localparam int LW        = 12;
  localparam int BYTES     = 8;
  localparam int BURST_MAX = 16;

  logic          clk;
  logic          reset;
  logic          s_sof;
  logic          w_sof;
  logic [AW-1:0] w_addr;
  logic [LW-1:0] line_beats;
  logic [LW-1:0] lines;
  logic [AW-1:0] stride;
  logic          frame_busy;
  logic          err_overrun;
  logic          awreadyDrv;
  logic          readyForce;
  logic          readyRandom;

  int            checkCount;
  int            errorCount;
  logic [39:0]   expQ[$];

  frame_wr_addr_gen_if #(.C_ADDR_WIDTH(AW)) axiIf ();

  assign axiIf.awready = awreadyDrv;

  frame_wr_addr_gen #(
    .C_ADDR_WIDTH(AW),
    .C_DATA_BYTES(BYTES),
    .C_BURST_MAX (BURST_MAX),
    .C_LINE_WIDTH(LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_sof      (s_sof),
    .w_sof      (w_sof),
    .w_addr     (w_addr),
    .line_beats (line_beats),
    .lines      (lines),
    .stride     (stride),
    .m_axi      (axiIf),
    .frame_busy (frame_busy),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // awready is owned by this process only; changes land 1 time unit after each rising edge.
  initial begin
    awreadyDrv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      awreadyDrv = readyRandom ? 1'($urandom_range(0, 1)) : readyForce;
    end
  end

  // Handshake seen at the falling edge completes on the following rising edge.
  always @(negedge clk) begin
    if (!reset && axiIf.awvalid && axiIf.awready) begin
      checkOutput("sbNotEmpty", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        checkOutput("burst", {24'd0, axiIf.awaddr, axiIf.awlen}, {24'd0, expQ.pop_front()});
      end
    end
  end

  function automatic void pushBurst(input logic [31:0] addr, input logic [7:0] len);
    expQ.push_back({addr, len});
  endfunction

  function automatic void pushFrame(input logic [31:0] base, input int lb, input int ln, input logic [31:0] st);
    for (int r = 0; r < ln; r++) begin
      int off;
      off = 0;
      while (off < lb) begin
        int n;
        n = ((lb - off) > BURST_MAX) ? BURST_MAX : (lb - off);
        pushBurst(base + 32'(r) * st + 32'(off * BYTES), 8'(n - 1));
        off += n;
      end
    end
  endfunction

  task automatic pulseSof(input logic expectWsof);
    @(posedge clk);
    #1;
    s_sof = 1'b1;
    #1;
    checkOutput("w_sof", 64'(w_sof), 64'(expectWsof));
    @(posedge clk);
    #1;
    s_sof = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int lb, input int ln, input logic [31:0] st);
    w_addr     = base;
    line_beats = LW'(lb);
    lines      = LW'(ln);
    stride     = st;
    pulseSof(1'b1);
  endtask

  task automatic waitAwvalid(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (axiIf.awvalid) break;
      @(posedge clk);
      #2;
    end
    checkOutput(tag, 64'(axiIf.awvalid), 64'd1);
  endtask

  task automatic waitDrain(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #2;
      if (expQ.size() == 0) break;
    end
    checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_busyDone"}, 64'(frame_busy), 64'd0);
  endtask

  initial begin
    int busyCount;
    int awCount;
    checkCount  = 0;
    errorCount  = 0;
    reset       = 1'b1;
    s_sof       = 1'b0;
    w_addr      = '0;
    line_beats  = '0;
    lines       = '0;
    stride      = '0;
    readyForce  = 1'b1;
    readyRandom = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awvalid", 64'(axiIf.awvalid), 64'd0);
    checkOutput("rst_awaddr", 64'(axiIf.awaddr), 64'd0);
    checkOutput("rst_awlen", 64'(axiIf.awlen), 64'd0);
    checkOutput("rst_busy", 64'(frame_busy), 64'd0);
    checkOutput("rst_overrun", 64'(err_overrun), 64'd0);
    checkOutput("rst_w_sof", 64'(w_sof), 64'd0);
    reset = 1'b0;

    // Single frame, one burst per row, with first-burst latency
    pushBurst(32'h1000_0000, 8'd15);
    pushBurst(32'h1000_0800, 8'd15);
    applyStimulus(32'h1000_0000, 16, 2, 32'h800);
    checkOutput("lat_latchBusy", 64'(frame_busy), 64'd1);
    checkOutput("lat_latchValid", 64'(axiIf.awvalid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_issueValid", 64'(axiIf.awvalid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_firstValid", 64'(axiIf.awvalid), 64'd1);
    waitDrain("single");

    // Row split into 16+16+8 beats
    pushBurst(32'h2000_0000, 8'd15);
    pushBurst(32'h2000_0080, 8'd15);
    pushBurst(32'h2000_0100, 8'd7);
    applyStimulus(32'h2000_0000, 40, 1, 32'h1000);
    waitDrain("split");

    // Backpressure holds the first burst steady
    readyForce = 1'b0;
    pushBurst(32'h4000_0000, 8'd15);
    pushBurst(32'h4000_0080, 8'd3);
    applyStimulus(32'h4000_0000, 20, 1, 32'h800);
    waitAwvalid("bp_awvalid");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_holdValid", 64'(axiIf.awvalid), 64'd1);
      checkOutput("bp_holdBurst", {24'd0, axiIf.awaddr, axiIf.awlen}, {24'd0, 32'h4000_0000, 8'd15});
      @(posedge clk);
      #2;
    end
    readyForce = 1'b1;
    waitDrain("bp");

    // Overrun: second s_sof while waiting, new inputs must not leak in
    readyForce = 1'b0;
    pushBurst(32'h5000_0000, 8'd15);
    pushBurst(32'h5000_1000, 8'd15);
    pushBurst(32'h5000_2000, 8'd15);
    applyStimulus(32'h5000_0000, 16, 3, 32'h1000);
    waitAwvalid("ovr_awvalid");
    w_addr = 32'h5555_0000;
    stride = 32'h40;
    checkOutput("ovr_errBefore", 64'(err_overrun), 64'd0);
    pulseSof(1'b0);
    checkOutput("ovr_errPulse", 64'(err_overrun), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("ovr_errCleared", 64'(err_overrun), 64'd0);
    readyForce = 1'b1;
    waitDrain("ovr");

    // Zero-size frame: busy for LATCH only, no bursts
    applyStimulus(32'h6000_0000, 8, 0, 32'h100);
    busyCount = 0;
    awCount   = 0;
    for (int i = 0; i < 6; i++) begin
      if (frame_busy) busyCount++;
      if (axiIf.awvalid) awCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("zero_busyCycles", 64'(busyCount), 64'd1);
    checkOutput("zero_awvalid", 64'(awCount), 64'd0);

`ifdef FRAME_WR_4K_SPLIT_EN
    // Page crossing splits the row at 0x3000_1000
    pushBurst(32'h3000_0FC0, 8'd7);
    pushBurst(32'h3000_1000, 8'd7);
    applyStimulus(32'h3000_0FC0, 16, 1, 32'h1000);
    waitDrain("page");
`endif

    // Random frames with random awready, page-aligned so both builds agree
    readyRandom = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int lb;
      int ln;
      logic [31:0] base;
      logic [31:0] st;
      lb   = $urandom_range(1, 70);
      ln   = $urandom_range(1, 4);
      base = 32'h6000_0000 + 32'(k) * 32'h0010_0000;
      st   = 32'h1000 * 32'($urandom_range(1, 3));
      pushFrame(base, lb, ln, st);
      applyStimulus(base, lb, ln, st);
      waitDrain("rand");
    end
    readyRandom = 1'b0;

    // Reset in the middle of a frame drops awvalid on the next edge
    readyForce = 1'b0;
    applyStimulus(32'h7000_0000, 16, 2, 32'h1000);
    waitAwvalid("mrst_awvalid");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_awvalidLow", 64'(axiIf.awvalid), 64'd0);
    checkOutput("mrst_busyLow", 64'(frame_busy), 64'd0);
    reset = 1'b0;
    readyForce = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mrst_stayIdle", 64'(axiIf.awvalid), 64'd0);
    checkOutput("final_sbEmpty", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/frame_wr_addr_gen.md
Name: frame_wr_addr_gen

Overview:
- Write-side front end of the triple/quad frame buffer scheme. It sits directly upstream of the buffer-arbitration stage.
- Converts the video stream's start-of-frame into the `w_sof` pulse for the arbiter, then captures the write buffer base address the arbiter hands back.
- Issues AXI4 write-address bursts that cover one frame: `lines` rows of `line_beats` data beats, with a row pitch of `stride` bytes.

Parameters:
- C_ADDR_WIDTH, 32, AXI/buffer address width
- C_DATA_BYTES, 8, bytes per AXI data beat (power of 2)
- C_BURST_MAX, 16, max beats per burst (1..256)
- C_LINE_WIDTH, 12, width of line_beats and lines inputs

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_sof  in  1  start-of-frame pulse from video stream (first pixel)
- w_sof  out  1  write-frame-switch pulse to buffer arbiter
- w_addr  in  C_ADDR_WIDTH  current write buffer base from arbiter
- line_beats  in  C_LINE_WIDTH  beats per row
- lines  in  C_LINE_WIDTH  rows per frame
- stride  in  C_ADDR_WIDTH  byte pitch between row starts
- m_axi_awaddr  out  C_ADDR_WIDTH  burst start address
- m_axi_awlen  out  8  beats-1
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address accept
- frame_busy  out  1  frame addressing in progress
- err_overrun  out  1  one-cycle pulse: s_sof dropped while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- w_sof = s_sof & (state==IDLE). This is combinational, so the arbiter switches buffers on that same edge.
- FSM states:
  - IDLE: on s_sof go to LATCH.
  - LATCH: sample w_addr (the arbiter's newly selected buffer). Sample line_beats, lines and stride into shadow registers. Set row_base=w_addr, row_idx=0, beat_off=0.
    - If line_beats==0 or lines==0, go to IDLE (no bursts).
    - Else go to ISSUE.
  - ISSUE: compute len=min(line_beats-beat_off, C_BURST_MAX). Register awaddr=row_base+beat_off*C_DATA_BYTES and awlen=len-1. Assert awvalid. Go to WAIT.
  - WAIT: hold awvalid, awaddr and awlen stable until awready. On the awready edge, deassert awvalid and set beat_off+=len.
    - If beat_off reaches line_beats: row_idx+=1, row_base+=stride, beat_off=0.
    - If row_idx reaches lines, go to IDLE; otherwise go to ISSUE.
- Throughput: one burst per 2 cycles at best (ISSUE→WAIT with awready=1).
- frame_busy=1 in LATCH, ISSUE and WAIT.
- Latency: s_sof at cycle 0 → LATCH at cycle 1 → first awvalid at cycle 3.
- Inputs are sampled only in LATCH. Later changes to w_addr, line_beats, lines or stride affect only the next frame.
- s_sof while state!=IDLE: no w_sof is produced, err_overrun pulses 1 cycle, and the current frame continues unchanged.
- Address arithmetic is modulo 2^C_ADDR_WIDTH; wrap is not flagged.
- beat_off and row_idx are C_LINE_WIDTH+1 bits wide, so no overflow is possible.
- reset asserted mid-frame: on the next edge awvalid=0 and state=IDLE. The AXI violation is accepted only under system reset.

Optional Feature:
- Macro: FRAME_WR_4K_SPLIT_EN.
- Defined: in ISSUE, len is further limited to (4096 - (awaddr mod 4096))/C_DATA_BYTES. No burst crosses a 4 KiB boundary, and the residue of the row is issued as extra bursts.
- Undefined: no boundary check. Software guarantees alignment: stride and base are 4 KiB aligned and row bytes are ≤4 KiB.

Test Plan:
- Single frame, 1 burst per row:
  - Stimulus: w_addr=0x1000_0000, line_beats=16, lines=2, stride=0x800, awready=1; pulse s_sof.
  - Response: w_sof same cycle; bursts (0x1000_0000, len 15) and (0x1000_0800, len 15); frame_busy falls after the 2nd accept.
- Row split:
  - Stimulus: line_beats=40, lines=1, base 0x2000_0000.
  - Response: bursts at 0x2000_0000/15, 0x2000_0080/15, 0x2000_0100/7.
- Backpressure:
  - Stimulus: awready low 5 cycles on the first burst.
  - Response: awvalid, awaddr and awlen constant for all 5 cycles; no second burst before accept.
- Overrun:
  - Stimulus: second s_sof during WAIT.
  - Response: w_sof stays 0, err_overrun=1 for one cycle, remaining burst addresses unchanged.
- Zero size:
  - Stimulus: lines=0 with s_sof.
  - Response: w_sof pulses, awvalid never asserts, frame_busy high exactly 1 cycle.
- 4K split (macro defined):
  - Stimulus: base 0x3000_0FC0, line_beats=16.
  - Response: bursts 0x3000_0FC0/7 and 0x3000_1000/7.
